// File: rtl/i2c_pkg.sv
// Shared types for the multi-line I2C sender: FSM state encoding and the
// line-select width helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STA,
        BIT,
        ACK,
        STP,
        FIN
    } state_e;

    // A single-line build still needs a one-bit select port.
    function automatic int sel_width(input int n_lines);
        return (n_lines > 1) ? $clog2(n_lines) : 1;
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-SCL-period timer: strobes once every CLK_DIV cycles while running
// and counts the four quarter phases of a bit.
module i2c_phase_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       clr_i,
    output logic       qstb_o,
    output logic [1:0] phase_o
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          qstb;

    always_comb begin
        qstb    = run_i && (cnt_q == CNT_LAST);
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = '0;
            phase_d = 2'd0;
        end else if (qstb) begin
            // The FSM clears the phase on a state change so every state starts at quarter 0.
            cnt_d   = '0;
            phase_d = clr_i ? 2'd0 : phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign qstb_o  = qstb;
    assign phase_o = phase_q;

endmodule

// File: rtl/i2c_multi_sender.sv
// Write-only I2C master that sends up to MAX_BYTES bytes on one of N_LINES
// open-drain SCL/SDA pairs, stopping early on a NACK.
module i2c_multi_sender
    import i2c_pkg::*;
#(
    parameter int N_LINES   = 2,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 25
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [sel_width(N_LINES)-1:0]      line_sel_i,
    input  logic [$clog2(MAX_BYTES+1)-1:0]     nbytes_i,
    input  logic [8*MAX_BYTES-1:0]             data_i,
    input  logic [N_LINES-1:0]                 sda_in_i,
    output logic [N_LINES-1:0]                 scl_oe_o,
    output logic [N_LINES-1:0]                 sda_oe_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               nack_o
);

    localparam int             LW        = sel_width(N_LINES);
    localparam int             NBW       = $clog2(MAX_BYTES + 1);
    localparam int             DW        = 8 * MAX_BYTES;
    localparam logic [NBW-1:0] NB_MAX    = NBW'(MAX_BYTES);
    localparam logic [LW:0]    N_LINES_W = (LW + 1)'(N_LINES);

    state_e           state_q, state_d;
    logic [LW-1:0]    line_q, line_d;
    logic [NBW-1:0]   nbytes_q, nbytes_d;
    logic [NBW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             nack_q, nack_d;

    logic             qstb, run, clr;
    logic [1:0]       phase;
    logic             scl_pull, sda_pull, busy, done;
    logic [N_LINES-1:0] line_hit;
    logic             sda_sel, start_bad;

    i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run_i   (run),
        .clr_i   (clr),
        .qstb_o  (qstb),
        .phase_o (phase)
    );

    always_comb begin
        line_hit = '0;
        for (int i = 0; i < N_LINES; i++) line_hit[i] = (line_q == LW'(i));
    end

    assign sda_sel   = |(sda_in_i & line_hit);
    assign start_bad = (nbytes_i == '0) || (nbytes_i > NB_MAX) ||
                       ({1'b0, line_sel_i} >= N_LINES_W);
    assign run       = (state_q == STA) || (state_q == BIT) ||
                       (state_q == ACK) || (state_q == STP);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        nbytes_d   = nbytes_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        nack_d     = nack_q;
        clr        = 1'b0;
        scl_pull   = 1'b0;
        sda_pull   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    line_d     = line_sel_i;
                    nbytes_d   = nbytes_i;
                    data_d     = data_i;
                    byte_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    nack_d     = start_bad;
                    state_d    = start_bad ? FIN : STA;
                end
            end
            STA: begin
                busy     = 1'b1;
                sda_pull = 1'b1;
                scl_pull = (phase == 2'd1);
                if (qstb && phase == 2'd1) begin
                    clr     = 1'b1;
                    state_d = BIT;
                end
            end
            BIT: begin
                busy     = 1'b1;
                sda_pull = ~data_q[DW-1];
                scl_pull = (phase == 2'd0) || (phase == 2'd3);
                if (qstb && phase == 2'd3) begin
                    // Shifting per bit leaves the next byte at the top after eight bits.
                    data_d    = {data_q[DW-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        clr     = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                busy     = 1'b1;
                scl_pull = (phase == 2'd0) || (phase == 2'd3);
                if (qstb && phase == 2'd1) nack_d = sda_sel;
                if (qstb && phase == 2'd3) begin
                    clr        = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    bit_cnt_d  = 3'd0;
                    state_d    = (nack_q || (byte_cnt_q + 1'b1 == nbytes_q)) ? STP : BIT;
                end
            end
            STP: begin
                busy     = 1'b1;
                sda_pull = 1'b1;
                scl_pull = (phase == 2'd0);
                if (qstb && phase == 2'd1) begin
                    clr     = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the payload
    // register is ordinary flops, so it is cleared by reset like the rest.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            line_q     <= '0;
            nbytes_q   <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            bit_cnt_q  <= 3'd0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            nbytes_q   <= nbytes_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            nack_q     <= nack_d;
        end
    end

    // Outputs decode the registered state, so reset releases every line at once.
    assign scl_oe_o = line_hit & {N_LINES{scl_pull}};
    assign sda_oe_o = line_hit & {N_LINES{sda_pull}};
    assign busy_o   = busy;
    assign done_o   = done;
    assign nack_o   = nack_q;

endmodule

// File: tb/tb_i2c_multi_sender.sv
// Self-checking bench: per-line I2C slave model with configurable ACK, a bus
// legality monitor, a vector table and hand-written reset/ignore sequences.
module tb_i2c_multi_sender;

    localparam int NL = 3;
    localparam int MB = 4;
    localparam int CD = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    sel   = '0;
    logic [2:0]    nb    = '0;
    logic [31:0]   data  = '0;
    logic [NL-1:0] sda_in, scl_oe, sda_oe;
    logic          busy, done, nack;
    logic [NL-1:0] scl_line, sda_line;
    logic [NL-1:0] pull = '0;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | pull);
    assign sda_in   = sda_line;

    i2c_multi_sender #(.N_LINES(NL), .MAX_BYTES(MB), .CLK_DIV(CD)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .line_sel_i (sel),
        .nbytes_i   (nb),
        .data_i     (data),
        .sda_in_i   (sda_in),
        .scl_oe_o   (scl_oe),
        .sda_oe_o   (sda_oe),
        .busy_o     (busy),
        .done_o     (done),
        .nack_o     (nack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave and monitor state, one entry per line.
    logic [NL-1:0] prev_scl = '1, prev_sda = '1, ack_ph = '0;
    int            bcnt[NL], byte_i[NL], rx_cnt[NL];
    int            starts[NL], stops[NL], oe_cnt[NL];
    logic [7:0]    shreg[NL];
    logic [7:0]    rx_mem[NL][8];
    int            nack_at[NL];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        for (int l = 0; l < NL; l++) begin
            prev_scl[l] <= scl_line[l];
            prev_sda[l] <= sda_line[l];
            if (scl_oe[l] || sda_oe[l]) oe_cnt[l] <= oe_cnt[l] + 1;
            if (prev_scl[l] && scl_line[l] && prev_sda[l] && !sda_line[l]) begin
                starts[l] <= starts[l] + 1;
                bcnt[l]   <= 0;
                byte_i[l] <= 0;
                rx_cnt[l] <= 0;
                ack_ph[l] <= 1'b0;
                pull[l]   <= 1'b0;
            end else if (prev_scl[l] && scl_line[l] && !prev_sda[l] && sda_line[l]) begin
                stops[l] <= stops[l] + 1;
            end else if (!prev_scl[l] && scl_line[l]) begin
                if (bcnt[l] < 8) begin
                    shreg[l] <= {shreg[l][6:0], sda_line[l]};
                    bcnt[l]  <= bcnt[l] + 1;
                end
            end else if (prev_scl[l] && !scl_line[l]) begin
                if (ack_ph[l]) begin
                    pull[l]   <= 1'b0;
                    ack_ph[l] <= 1'b0;
                    bcnt[l]   <= 0;
                    byte_i[l] <= byte_i[l] + 1;
                end else if (bcnt[l] == 8) begin
                    if (rx_cnt[l] < 8) rx_mem[l][rx_cnt[l]] <= shreg[l];
                    rx_cnt[l] <= rx_cnt[l] + 1;
                    pull[l]   <= (byte_i[l] != nack_at[l]);
                    ack_ph[l] <= 1'b1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int t0     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_pulse(input logic [1:0] s, input logic [2:0] n, input logic [31:0] d);
        @(negedge clk);
        sel   = s;
        nb    = n;
        data  = d;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        while (!done && (cyc - t0) < budget) @(negedge clk);
        n = cyc - t0;
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
    endtask

    function automatic logic len_ok(input int n, input int nbytes);
        int exp_len;
        exp_len = 36 * CD * nbytes + 4 * CD;
        return (n >= exp_len - 2) && (n <= exp_len + 2);
    endfunction

    function automatic int sum_starts();
        int s = 0;
        for (int l = 0; l < NL; l++) s += starts[l];
        return s;
    endfunction

    function automatic int sum_stops();
        int s = 0;
        for (int l = 0; l < NL; l++) s += stops[l];
        return s;
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  nb;
        logic [31:0] data;
        int          nack_at;
        logic        active;
        int          exp_rx;
        logic        exp_nack;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, st0, sp0, dc0;
        int oe0[NL];
        int other;
        vec_t v;

        vecs[0] = '{2'd1, 3'd4, 32'hC060_C800, -1, 1'b1, 4, 1'b0};
        vecs[1] = '{2'd0, 3'd2, 32'hABCD_0000,  0, 1'b1, 1, 1'b1};
        vecs[2] = '{2'd0, 3'd0, 32'hDEAD_BEEF, -1, 1'b0, 0, 1'b1};
        vecs[3] = '{2'd1, 3'd5, 32'h1234_5678, -1, 1'b0, 0, 1'b1};
        vecs[4] = '{2'd3, 3'd1, 32'hFF00_0000, -1, 1'b0, 0, 1'b1};
        vecs[5] = '{2'd2, 3'd1, 32'h5A00_0000, -1, 1'b1, 1, 1'b0};
        vecs[6] = '{2'd0, 3'd3, 32'h1234_5600,  1, 1'b1, 2, 1'b1};
        for (int l = 0; l < NL; l++) nack_at[l] = -1;

        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 3'b000);
        check("rst_sda_oe", sda_oe, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_nack", nack, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            for (int l = 0; l < NL; l++) begin
                nack_at[l] = v.nack_at;
                oe0[l]     = oe_cnt[l];
            end
            st0 = sum_starts();
            sp0 = sum_stops();
            dc0 = done_cnt;
            start_pulse(v.sel, v.nb, v.data);
            check($sformatf("v%0d_busy_after_start", i), busy, v.active);
            wait_done(2000, n);
            if (!v.active) check($sformatf("v%0d_done_latency", i), n, 1);
            if (v.active && !v.exp_nack) check($sformatf("v%0d_length", i), len_ok(n, int'(v.nb)), 1'b1);
            check($sformatf("v%0d_nack", i), nack, v.exp_nack);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done_count", i), done_cnt - dc0, 1);
            check($sformatf("v%0d_starts", i), sum_starts() - st0, v.active);
            check($sformatf("v%0d_stops", i), sum_stops() - sp0, v.active);
            other = 0;
            for (int l = 0; l < NL; l++)
                if (!v.active || l != int'(v.sel)) other += oe_cnt[l] - oe0[l];
            check($sformatf("v%0d_other_line_oe", i), other, 0);
            if (v.active) begin
                check($sformatf("v%0d_rx_count", i), rx_cnt[v.sel], v.exp_rx);
                for (int j = 0; j < v.exp_rx; j++)
                    check($sformatf("v%0d_rx_byte%0d", i, j), rx_mem[v.sel][j], v.data[31-8*j -: 8]);
            end
        end

        // START during byte 1 with new inputs must be ignored.
        for (int l = 0; l < NL; l++) nack_at[l] = -1;
        oe0[0] = oe_cnt[0];
        dc0    = done_cnt;
        start_pulse(2'd1, 3'd2, 32'h1122_0000);
        repeat (216) @(negedge clk);
        check("ign_busy_mid", busy, 1'b1);
        sel   = 2'd0;
        nb    = 3'd1;
        data  = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, n);
        check("ign_length", len_ok(n, 2), 1'b1);
        check("ign_nack", nack, 1'b0);
        repeat (3) @(negedge clk);
        check("ign_done_count", done_cnt - dc0, 1);
        check("ign_rx_count", rx_cnt[1], 2);
        check("ign_rx_byte0", rx_mem[1][0], 8'h11);
        check("ign_rx_byte1", rx_mem[1][1], 8'h22);
        check("ign_line0_oe", oe_cnt[0] - oe0[0], 0);

        // Reset during bit 5 of byte 2 (a 0 bit, so SDA is being pulled).
        start_pulse(2'd1, 3'd4, 32'hFFFF_00FF);
        repeat (381) @(negedge clk);
        check("prerst_sda_oe", sda_oe, 3'b010);
        dc0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("midrst_scl_oe", scl_oe, 3'b000);
        check("midrst_sda_oe", sda_oe, 3'b000);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - dc0, 0);
        check("midrst_nack", nack, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_pulse(2'd1, 3'd1, 32'hA500_0000);
        check("post_rst_busy", busy, 1'b1);
        wait_done(2000, n);
        check("post_rst_length", len_ok(n, 1), 1'b1);
        check("post_rst_nack", nack, 1'b0);
        repeat (3) @(negedge clk);
        check("post_rst_rx_count", rx_cnt[1], 1);
        check("post_rst_rx_byte", rx_mem[1][0], 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
